mem_access_unit: RTL and testbench

Memory-stage load/store engine sitting directly downstream of the pipelined datapath. It consumes the M-stage address (`aluoutM`) and store data (`writedataM`), and drives a request/acknowledge data bus with byte enables. It returns an aligned, sign- or zero-extended `readdataM` to the writeback register. It stalls the pipeline until the bus transfer completes and flags misaligned addresses instead of issuing them.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: request/acknowledge bus master with
// byte enables, load formatting, misalignment detection and pipeline stall.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_be,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;

    logic        w_misal;
    logic        w_start;
    logic        w_capture;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    always_comb begin
        w_misal = 1'b0;
        case (memsizeM)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = aluoutM[0];
            default: w_misal = |aluoutM[1:0];
        endcase
    end

    assign adelM   = w_misal & memreqM & ~memwriteM;
    assign adesM   = w_misal & memreqM & memwriteM;
    assign w_start = (r_state == S_IDLE) & memreqM & ~w_misal;

    // Loads always enable every lane; the bus returns the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writedataM;
        case (memsizeM)
            2'b00: begin
                w_wdata = {4{writedataM[7:0]}};
                if (memwriteM)
                    w_be = 4'b0001 << aluoutM[1:0];
            end
            2'b01: begin
                w_wdata = {2{writedataM[15:0]}};
                if (memwriteM)
                    w_be = aluoutM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = writedataM;
                w_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_byte = data_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = data_rdata[7:0];
            2'b01:   w_byte = data_rdata[15:8];
            2'b10:   w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
    end

    assign w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        w_fmt = data_rdata;
        case (r_size)
            2'b00:   w_fmt = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_fmt = {{16{r_sign & w_half[15]}}, w_half};
            default: w_fmt = data_rdata;
        endcase
    end

    // A data_ok seen in ADDR only counts together with addr_ok.
    assign w_capture = ~r_wr & data_data_ok &
                       (((r_state == S_ADDR) & data_addr_ok) |
                        (r_state == S_DATA));

    always_comb begin
        w_next = r_state;
        stallM = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    stallM = 1'b1;
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                stallM = 1'b1;
                if (data_addr_ok)
                    w_next = data_data_ok ? S_DONE : S_DATA;
            end
            S_DATA: begin
                stallM = 1'b1;
                if (data_data_ok)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr  <= aluoutM;
                r_size  <= memsizeM;
                r_sign  <= memsignM;
                r_wr    <= memwriteM;
                r_wdata <= w_wdata;
                r_be    <= w_be;
            end
            if (w_capture)
                r_rdata <= w_fmt;
        end
    end

    assign readdataM  = r_rdata;
    assign data_req   = (r_state == S_ADDR);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_be    = r_be;
    assign data_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle comparison against a
// transaction-level model plus literal spot checks.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreqM;
    logic        memwriteM;
    logic [1:0]  memsizeM;
    logic        memsignM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .memreqM      (memreqM),
        .memwriteM    (memwriteM),
        .memsizeM     (memsizeM),
        .memsignM     (memsignM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_be      (data_be),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected values written by the driver, checked by the compare process.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_adel, exp_ades;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;

    int stall_total = 0;
    int req_total   = 0;

    int          pin_seq  = 0;
    int          pin_done = 0;
    int          pin_kind;
    int          pin_base;
    logic [31:0] pin_exp;
    string       pin_name;

    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic wr, input logic [1:0] sz,
                                        input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!wr) return 4'hF;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd % 256) * 32'h01010101;
        if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] lane;
        if (sz == 2'd0) begin
            lane = (rd >> (8 * (a % 4))) % 256;
            if (sg && lane >= 128) lane = lane - 256;
            return lane;
        end
        if (sz == 2'd1) begin
            lane = (rd >> (16 * ((a / 2) % 2))) % 65536;
            if (sg && lane >= 32768) lane = lane - 65536;
            return lane;
        end
        return rd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallM", 32'(stallM), 32'(exp_stall));
            chk("adelM", 32'(adelM), 32'(exp_adel));
            chk("adesM", 32'(adesM), 32'(exp_ades));
            chk("data_req", 32'(data_req), 32'(exp_req));
            chk("readdataM", readdataM, exp_rd);
            if (exp_req) begin
                chk("data_addr", data_addr, exp_addr);
                chk("data_wr", 32'(data_wr), 32'(exp_wr));
                chk("data_size", 32'(data_size), 32'(exp_size));
                chk("data_be", 32'(data_be), 32'(exp_be));
                if (exp_wr)
                    chk("data_wdata", data_wdata, exp_wd);
            end
            if (stallM === 1'b1) stall_total++;
            if (data_req === 1'b1) req_total++;
            if (pin_seq != pin_done) begin
                pin_done = pin_seq;
                case (pin_kind)
                    0: chk(pin_name, readdataM, pin_exp);
                    1: chk(pin_name, 32'(data_be), pin_exp);
                    2: chk(pin_name, data_wdata, pin_exp);
                    3: chk(pin_name, 32'(stall_total - pin_base), pin_exp);
                    4: chk(pin_name, 32'(req_total - pin_base), pin_exp);
                    default: chk(pin_name, data_addr, pin_exp);
                endcase
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cyc();
            memreqM      = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            exp_stall    = 1'b0;
            exp_req      = 1'b0;
            exp_adel     = 1'b0;
            exp_ades     = 1'b0;
        end
    endtask

    task automatic pin(input int kind, input logic [31:0] exp, input string name);
        pin_kind = kind;
        pin_exp  = exp;
        pin_name = name;
        pin_seq++;
        @(negedge clk);
        idle(1);
    endtask

    // One M-stage access: na ADDR wait cycles, nd DATA cycles (0 = both oks together).
    task automatic xfer(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int na, input int nd,
                        input logic stray);
        logic mis;
        next_cyc();
        memreqM      = 1'b1;
        memwriteM    = wr;
        memsizeM     = sz;
        memsignM     = sg;
        aluoutM      = a;
        writedataM   = wd;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = ~rd;
        mis          = m_misal(sz, a);
        exp_adel     = mis & ~wr;
        exp_ades     = mis & wr;
        exp_req      = 1'b0;
        exp_stall    = ~mis;
        if (!mis) begin
            exp_addr = a;
            exp_wr   = wr;
            exp_size = sz;
            exp_be   = m_be(wr, sz, a);
            exp_wd   = m_wd(sz, wd);
            for (int k = 0; k <= na; k++) begin
                next_cyc();
                exp_stall    = 1'b1;
                exp_req      = 1'b1;
                data_addr_ok = (k == na);
                data_data_ok = (k == na) ? (nd == 0) : stray;
                data_rdata   = (k == na && nd == 0) ? rd : ~rd;
            end
            for (int j = 1; j <= nd; j++) begin
                next_cyc();
                exp_req      = 1'b0;
                data_addr_ok = 1'b0;
                data_data_ok = (j == nd);
                data_rdata   = (j == nd) ? rd : ~rd;
            end
            next_cyc();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            exp_stall    = 1'b0;
            exp_req      = 1'b0;
            if (!wr) exp_rd = m_load(rd, a, sz, sg);
        end
    endtask

    initial begin
        rst          = 1'b0;
        memreqM      = 1'b0;
        memwriteM    = 1'b0;
        memsizeM     = 2'd0;
        memsignM     = 1'b0;
        aluoutM      = '0;
        writedataM   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        exp_stall    = 1'b0;
        exp_req      = 1'b0;
        exp_adel     = 1'b0;
        exp_ades     = 1'b0;
        exp_rd       = '0;
        exp_addr     = '0;
        exp_wr       = 1'b0;
        exp_size     = '0;
        exp_be       = '0;
        exp_wd       = '0;

        next_cyc();
        chk_en = 1'b1;
        pin(0, 32'h0, "reset_readdata");
        pin(1, 32'h0, "reset_be");
        pin(5, 32'h0, "reset_addr");
        rst = 1'b1;
        idle(1);

        pin_base = stall_total;
        xfer(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 32'h0, 0, 0, 1'b0);
        pin(1, 32'hF, "sw_be");
        pin(2, 32'h12345678, "sw_wdata");
        pin(3, 32'd2, "sw_stall_cycles");

        xfer(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
        pin(0, 32'hFFFFFF80, "lb_signed");

        xfer(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 1'b0);
        pin(0, 32'h000080FF, "lhu");

        xfer(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, 32'h0, 0, 0, 1'b0);
        pin(1, 32'h2, "sb_be");
        pin(2, 32'hABABABAB, "sb_wdata");
        pin(0, 32'h000080FF, "store_keeps_readdata");

        pin_base = stall_total;
        xfer(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0);
        pin(3, 32'd7, "lw_wait_stall_cycles");
        pin_base = req_total - 4;
        pin(4, 32'd4, "lw_wait_req_cycles");
        pin(0, 32'hCAFEF00D, "lw_wait_data");

        pin_base = req_total;
        xfer(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11111111, 0, 0, 1'b0);
        idle(1);
        pin(4, 32'd0, "adel_no_req");

        xfer(1'b1, 2'd1, 1'b0, 32'h101, 32'hBEEF, 32'h0, 0, 0, 1'b0);
        idle(1);

        xfer(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 32'h9ABC0000, 2, 0, 1'b1);
        pin(0, 32'hFFFF9ABC, "lh_stray_ignored");

        xfer(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 1, 1, 1'b0);
        pin(1, 32'hC, "sh_hi_be");
        pin(2, 32'hBEEFBEEF, "sh_wdata");

        xfer(1'b0, 2'd3, 1'b0, 32'h10C, 32'h0, 32'h76543210, 1, 1, 1'b0);
        pin(0, 32'h76543210, "size3_word");

        // Reset while waiting in DATA, then a stray data_ok.
        next_cyc();
        memreqM   = 1'b1;
        memwriteM = 1'b0;
        memsizeM  = 2'd2;
        memsignM  = 1'b0;
        aluoutM   = 32'h200;
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        exp_addr  = 32'h200;
        exp_wr    = 1'b0;
        exp_size  = 2'd2;
        exp_be    = 4'hF;
        next_cyc();
        exp_req      = 1'b1;
        data_addr_ok = 1'b1;
        next_cyc();
        exp_req      = 1'b0;
        data_addr_ok = 1'b0;
        next_cyc();
        rst     = 1'b0;
        memreqM = 1'b0;
        next_cyc();
        rst          = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        exp_stall    = 1'b0;
        exp_rd       = 32'h0;
        next_cyc();
        data_data_ok = 1'b0;
        pin(0, 32'h0, "reset_stray_ignored");
        pin(5, 32'h0, "reset_clears_addr");

        xfer(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h000000F0, 0, 0, 1'b0);
        pin(0, 32'h000000F0, "lbu_after_reset");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
